sys_bus_mem_responder: RTL

Memory-side responder for the cache's system bus: accepts read and write requests from the cache controller, models a word-addressed backing memory with byte-strobe writes, and returns read data or a write response after a programmable latency. It is the far end of the readAddr/readData/writeAddr/writeData/writeResp handshakes driven by the cache controller, and serves as both the simulation main memory and the synthesizable on-chip backing store.

---
 rtl/sys_bus_pkg.sv | 31 +++
 rtl/sys_bus_mem_array.sv | 48 ++++
 rtl/sys_bus_mem_responder.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/sys_bus_pkg.sv
// Shared system-bus definitions: response codes (also used by the cache
// controller), responder FSM state encoding and the address legality helper.
package sys_bus_pkg;

    localparam logic [31:0] RESP_OKAY   = 32'h0000_0000;
    localparam logic [31:0] RESP_SLVERR = 32'h0000_0001;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_R_BUSY = 3'd1;
    localparam logic [2:0] ST_R_DATA = 3'd2;
    localparam logic [2:0] ST_W_BUSY = 3'd3;
    localparam logic [2:0] ST_W_RESP = 3'd4;

    typedef enum logic [2:0] {
        StIdle  = ST_IDLE,
        StRBusy = ST_R_BUSY,
        StRData = ST_R_DATA,
        StWBusy = ST_W_BUSY,
        StWResp = ST_W_RESP
    } state_e;

    // A byte address is usable when it is word aligned and falls inside the array.
    // The compare is done at 34 bits so 4*depth_words cannot overflow.
    function automatic logic addr_legal(input logic [31:0] addr,
                                        input int unsigned depth_words);
        logic [33:0] limit;
        limit = 34'(depth_words) << 2;
        return ({2'b00, addr} < limit) && (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/sys_bus_mem_array.sv
// Single-port DEPTH_WORDS x 32 storage with per-byte write enables and a
// registered read port.
//   clk, rst   : clock, async active-high reset (read register only)
//   rd_en_i    : load rdata_o from the addressed word
//   rd_clr_i   : load rdata_o with zero (rejected read)
//   wr_be_i    : byte write enables for the addressed word
//   addr_i     : word index
//   wdata_i    : write word
//   rdata_o    : read word, held until the next rd_en_i/rd_clr_i
module sys_bus_mem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en_i,
    input  logic          rd_clr_i,
    input  logic [3:0]    wr_be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (wr_be_i[b]) begin
                mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem_q[addr_i];
        end else if (rd_clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sys_bus_mem_responder.sv
// Memory-side responder for the cache system bus. Accepts one read or write at a
// time, waits LATENCY cycles, then presents read data or a write response and
// holds it until the initiator takes it.
//   clk, rst                          : clock, async active-high reset
//   readAddr_valid/readAddr/_ready    : read request channel
//   readData_valid/readData/_ready    : read data channel
//   writeAddr_valid/writeAddr/_ready  : write address channel
//   writeData_valid/writeData/Strb/_ready : write data channel
//   writeResp_valid/writeResp_msg/_ready  : write response channel
module sys_bus_mem_responder
    import sys_bus_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        readAddr_valid,
    input  logic [31:0] readAddr,
    output logic        readAddr_ready,
    output logic        readData_valid,
    output logic [31:0] readData,
    input  logic        readData_ready,
    input  logic        writeAddr_valid,
    input  logic [31:0] writeAddr,
    output logic        writeAddr_ready,
    input  logic        writeData_valid,
    input  logic [31:0] writeData,
    input  logic [3:0]  writeStrb,
    output logic        writeData_ready,
    output logic        writeResp_valid,
    output logic [31:0] writeResp_msg,
    input  logic        writeResp_ready
);

    localparam int unsigned AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  CntInit = 4'(LATENCY - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  strb_q;
    logic        rvalid_q;
    logic        bvalid_q;
    logic [31:0] bmsg_q;

    logic        addr_ok;
    logic        cnt_done;
    logic        arr_rd_en;
    logic        arr_rd_clr;
    logic [3:0]  arr_wr_be;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            rvalid_q <= 1'b0;
            bvalid_q <= 1'b0;
            bmsg_q   <= RESP_OKAY;
        end else begin
            unique case (state_q)
                StIdle: begin
                    // Read has priority; a colliding write simply stays pending.
                    if (readAddr_valid) begin
                        addr_q  <= readAddr;
                        cnt_q   <= CntInit;
                        state_q <= StRBusy;
                    end else if (writeAddr_valid && writeData_valid) begin
                        addr_q  <= writeAddr;
                        wdata_q <= writeData;
                        strb_q  <= writeStrb;
                        cnt_q   <= CntInit;
                        state_q <= StWBusy;
                    end
                end
                StRBusy: begin
                    if (cnt_done) begin
                        rvalid_q <= 1'b1;
                        state_q  <= StRData;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StRData: begin
                    if (readData_ready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                StWBusy: begin
                    if (cnt_done) begin
                        bvalid_q <= 1'b1;
                        bmsg_q   <= addr_ok ? RESP_OKAY : RESP_SLVERR;
                        state_q  <= StWResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StWResp: begin
                    if (writeResp_ready) begin
                        bvalid_q <= 1'b0;
                        state_q  <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Array access happens on the same edge the FSM leaves the busy state, so
    // the registered read data and the committed write line up with the response.
    always_comb begin
        addr_ok    = addr_legal(addr_q, DEPTH_WORDS);
        cnt_done   = (cnt_q == 4'd0);
        arr_rd_en  = 1'b0;
        arr_rd_clr = 1'b0;
        arr_wr_be  = 4'b0000;
        if (state_q == StRBusy && cnt_done) begin
            arr_rd_en  = addr_ok;
            arr_rd_clr = !addr_ok;
        end
        if (state_q == StWBusy && cnt_done && addr_ok) begin
            arr_wr_be = strb_q;
        end
    end

    sys_bus_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_mem_array (
        .clk      (clk),
        .rst      (rst),
        .rd_en_i  (arr_rd_en),
        .rd_clr_i (arr_rd_clr),
        .wr_be_i  (arr_wr_be),
        .addr_i   (addr_q[AW+1:2]),
        .wdata_i  (wdata_q),
        .rdata_o  (readData)
    );

    assign readAddr_ready  = (state_q == StIdle);
    assign writeAddr_ready = (state_q == StIdle) && !readAddr_valid;
    assign writeData_ready = (state_q == StIdle) && !readAddr_valid;
    assign readData_valid  = rvalid_q;
    assign writeResp_valid = bvalid_q;
    assign writeResp_msg   = bmsg_q;

endmodule
